regfile_wb: RTL

- Writeback-side register file for the 32-bit RISC core.
- Consumes the selected writeback bus (ALU-or-memory result) plus destination index and write-enable. Commits the value on the clock edge.
- Provides two combinational read ports to decode.
- Keeps a per-register busy scoreboard so decode can detect RAW hazards on in-flight writers.
- Counts committed writebacks for debug/perf.

---
 rtl/regfile_wb.sv | 91 +++++++++
 1 files changed

// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb
// Brief    : Writeback register file with two combinational read ports,
//            per-register busy scoreboard and committed-writeback counter.
//            Optional macro REGFILE_BYPASS_EN enables write-through forwarding.
// Revision : 1.0
// ============================================================================
module regfile_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [31:0]       wb_count
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [31:0]         r_wb_count;

    logic                w_commit;
    logic                w_issue;
    logic [NUM_REGS-1:0] w_busy_nxt;

    assign w_commit = wb_we && (wb_rd != '0);
    assign w_issue  = iss_valid && (iss_rd != '0);

    // Issue is applied after the clear so a same-register collision leaves
    // the new writer outstanding.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_commit) begin
            w_busy_nxt[wb_rd] = 1'b0;
        end
        if (w_issue) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy     <= '0;
            r_wb_count <= '0;
        end else begin
            if (w_commit) begin
                r_regs[wb_rd] <= wb_data;
                r_wb_count    <= r_wb_count + 32'd1;
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign wb_count = r_wb_count;

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : r_regs[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : r_regs[rs2_addr];
        rs1_busy = r_busy[rs1_addr];
        rs2_busy = r_busy[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        // w_commit already excludes r0, so r0 is never forwarded.
        if (w_commit && (rs1_addr == wb_rd)) begin
            rs1_data = wb_data;
            rs1_busy = w_issue && (iss_rd == wb_rd);
        end
        if (w_commit && (rs2_addr == wb_rd)) begin
            rs2_data = wb_data;
            rs2_busy = w_issue && (iss_rd == wb_rd);
        end
`endif
    end

endmodule
`default_nettype wire
